// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, ALU opcodes and bubble values for the ID/EX stage
package id_ex_stage_pkg;
    localparam int DATA_W  = 16;
    localparam int RADDR_W = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_LHB = 3'b001,
        ALU_SUB = 3'b010,
        ALU_AND = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_ctrl_e;

    localparam logic [DATA_W-1:0]  BUBBLE_DATA  = '0;
    localparam logic [2:0]         BUBBLE_CTRL  = ALU_ADD;
    localparam logic [3:0]         BUBBLE_SHAMT = '0;
    localparam logic [RADDR_W-1:0] BUBBLE_RD    = '0;

    // Only arithmetic ops produce meaningful overflow/negative results.
    function automatic logic sets_ov_ne(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side instruction bundle in, EX-side operands/control out
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic               id_valid;
    logic [DATA_W-1:0]  id_src0;
    logic [DATA_W-1:0]  id_src1;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic [2:0]         id_ctrl;
    logic [3:0]         id_shamt;
    logic               id_aluOp;
    logic               id_we;
    logic [RADDR_W-1:0] id_rd;

    logic               ex_valid;
    logic [DATA_W-1:0]  ex_src0;
    logic [DATA_W-1:0]  ex_src1;
    logic [2:0]         ex_ctrl;
    logic [3:0]         ex_shamt;
    logic               ex_aluOp;
    logic               ex_we;
    logic [RADDR_W-1:0] ex_rd;

    modport master (
        output id_valid, id_src0, id_src1, id_rs, id_rt, id_ctrl, id_shamt, id_aluOp, id_we, id_rd,
        input  ex_valid, ex_src0, ex_src1, ex_ctrl, ex_shamt, ex_aluOp, ex_we, ex_rd
    );

    modport slave (
        input  id_valid, id_src0, id_src1, id_rs, id_rt, id_ctrl, id_shamt, id_aluOp, id_we, id_rd,
        output ex_valid, ex_src0, ex_src1, ex_ctrl, ex_shamt, ex_aluOp, ex_we, ex_rd
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - per-operand RAW forwarding select, EX/MEM over MEM/WB, R0 never forwarded
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  src,
    input  logic               exmem_we,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_data,
    input  logic               memwb_we,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_data,
    output logic [DATA_W-1:0]  data
);
    logic nonzero;
    assign nonzero = (addr != '0);

    always_comb begin
        data = src;
        if (nonzero && exmem_we && (exmem_rd == addr)) begin
            data = exmem_data;
        end else if (nonzero && memwb_we && (memwb_rd == addr)) begin
            data = memwb_data;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, stall/flush and the ov/zr/ne flag register
// Optional forwarding muxes enabled by defining ID_EX_FWD_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    id_ex_stage_if.slave       pipe,
    input  logic               exmem_we,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_data,
    input  logic               memwb_we,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_data,
    input  logic               alu_ov,
    input  logic               alu_zr,
    input  logic               alu_ne,
    output logic               flag_ov,
    output logic               flag_zr,
    output logic               flag_ne
);
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;

`ifdef ID_EX_FWD_EN
    id_ex_stage_fwd_mux u_fwd0 (
        .addr(pipe.id_rs), .src(pipe.id_src0),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .data(op0)
    );
    id_ex_stage_fwd_mux u_fwd1 (
        .addr(pipe.id_rt), .src(pipe.id_src1),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .data(op1)
    );
`else
    // Without forwarding the hazard unit stalls, so producer ports are only sunk.
    assign op0 = pipe.id_src0;
    assign op1 = pipe.id_src1;
    wire unused_fwd = &{1'b0, exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd,
                        memwb_data, pipe.id_rs, pipe.id_rt};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe.ex_valid <= 1'b0;
            pipe.ex_src0  <= BUBBLE_DATA;
            pipe.ex_src1  <= BUBBLE_DATA;
            pipe.ex_ctrl  <= BUBBLE_CTRL;
            pipe.ex_shamt <= BUBBLE_SHAMT;
            pipe.ex_aluOp <= 1'b0;
            pipe.ex_we    <= 1'b0;
            pipe.ex_rd    <= BUBBLE_RD;
            flag_ov       <= 1'b0;
            flag_zr       <= 1'b0;
            flag_ne       <= 1'b0;
        end else begin
            if (flush) begin
                pipe.ex_valid <= 1'b0;
                pipe.ex_src0  <= BUBBLE_DATA;
                pipe.ex_src1  <= BUBBLE_DATA;
                pipe.ex_ctrl  <= BUBBLE_CTRL;
                pipe.ex_shamt <= BUBBLE_SHAMT;
                pipe.ex_aluOp <= 1'b0;
                pipe.ex_we    <= 1'b0;
                pipe.ex_rd    <= BUBBLE_RD;
            end else if (!stall) begin
                pipe.ex_valid <= pipe.id_valid;
                pipe.ex_src0  <= op0;
                pipe.ex_src1  <= op1;
                pipe.ex_ctrl  <= pipe.id_ctrl;
                pipe.ex_shamt <= pipe.id_shamt;
                pipe.ex_aluOp <= pipe.id_aluOp & pipe.id_valid;
                pipe.ex_we    <= pipe.id_we & pipe.id_valid;
                pipe.ex_rd    <= pipe.id_rd;
            end

            // A flush squashes ID only; the instruction already in EX still retires its flags.
            if (pipe.ex_valid && !stall) begin
                if (pipe.ex_aluOp) begin
                    flag_zr <= alu_zr;
                end
                if (sets_ov_ne(pipe.ex_ctrl)) begin
                    flag_ov <= alu_ov;
                    flag_ne <= alu_ne;
                end
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef ID_EX_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               flush;
    logic               exmem_we;
    logic [RADDR_W-1:0] exmem_rd;
    logic [DATA_W-1:0]  exmem_data;
    logic               memwb_we;
    logic [RADDR_W-1:0] memwb_rd;
    logic [DATA_W-1:0]  memwb_data;
    logic               alu_ov;
    logic               alu_zr;
    logic               alu_ne;
    logic               flag_ov;
    logic               flag_zr;
    logic               flag_ne;

    int total = 0;
    int bad   = 0;

    id_ex_stage_if pipe ();

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pipe(pipe),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_ne(alu_ne),
        .flag_ov(flag_ov), .flag_zr(flag_zr), .flag_ne(flag_ne)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [2:0]  ctrl;
        logic [3:0]  sh;
        logic        aop;
        logic        we;
        logic [3:0]  rd;
        logic        ov;
        logic        zr;
        logic        ne;
    } mstate_t;

    mstate_t m;

    function automatic logic [15:0] ref_operand(input logic [3:0] a, input logic [15:0] raw);
        if (FWD_ON && a != 4'd0 && exmem_we && exmem_rd == a) return exmem_data;
        if (FWD_ON && a != 4'd0 && memwb_we && memwb_rd == a) return memwb_data;
        return raw;
    endfunction

    // Advance the reference one clock from the inputs seen before the edge.
    task automatic tick();
        mstate_t n;
        n = m;
        if (m.v && !stall) begin
            if (m.aop) n.zr = alu_zr;
            if (m.ctrl == 3'b000 || m.ctrl == 3'b010) begin
                n.ov = alu_ov;
                n.ne = alu_ne;
            end
        end
        if (flush) begin
            n.v = 0; n.s0 = 0; n.s1 = 0; n.ctrl = 0; n.sh = 0; n.aop = 0; n.we = 0; n.rd = 0;
        end else if (!stall) begin
            n.v    = pipe.id_valid;
            n.s0   = ref_operand(pipe.id_rs, pipe.id_src0);
            n.s1   = ref_operand(pipe.id_rt, pipe.id_src1);
            n.ctrl = pipe.id_ctrl;
            n.sh   = pipe.id_shamt;
            n.aop  = pipe.id_aluOp & pipe.id_valid;
            n.we   = pipe.id_we & pipe.id_valid;
            n.rd   = pipe.id_rd;
        end
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic drive_id(input logic v, input logic [15:0] s0, input logic [15:0] s1,
                            input logic [3:0] rs, input logic [3:0] rt, input logic [2:0] ctrl,
                            input logic [3:0] sh, input logic aop, input logic we, input logic [3:0] rd);
        pipe.id_valid = v;  pipe.id_src0 = s0;   pipe.id_src1 = s1;
        pipe.id_rs    = rs; pipe.id_rt   = rt;   pipe.id_ctrl = ctrl;
        pipe.id_shamt = sh; pipe.id_aluOp = aop; pipe.id_we   = we; pipe.id_rd = rd;
    endtask

    task automatic producers_off();
        exmem_we = 0; exmem_rd = 0; exmem_data = 0;
        memwb_we = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0;
        alu_ov = 0; alu_zr = 0; alu_ne = 0;
        producers_off();
        drive_id(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        m = '0;
        total++;
        if ({pipe.ex_valid, pipe.ex_src0, pipe.ex_we} !== 18'd0) begin
            bad++; $display("FAIL reset_ex got %h exp 0", {pipe.ex_valid, pipe.ex_src0, pipe.ex_we});
        end
        total++;
        if ({flag_ov, flag_zr, flag_ne} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got %b exp 000", {flag_ov, flag_zr, flag_ne});
        end
        drive_id(1, 16'h0005, 16'h0006, 1, 2, ALU_ADD, 0, 1, 1, 4);
        alu_ov = 1; alu_zr = 1; alu_ne = 1;
        tick();
        tick();
        total++;
        if ({pipe.ex_valid, flag_ov, flag_zr, flag_ne} !== 4'b1111) begin
            bad++; $display("FAIL reset_setup got %b exp 1111", {pipe.ex_valid, flag_ov, flag_zr, flag_ne});
        end
        #2 rst = 1;
        #1;
        total++;
        if ({pipe.ex_valid, pipe.ex_src0, pipe.ex_we, pipe.ex_aluOp, flag_ov, flag_zr, flag_ne} !== 22'd0) begin
            bad++; $display("FAIL reset_async got %h exp 0",
                            {pipe.ex_valid, pipe.ex_src0, pipe.ex_we, pipe.ex_aluOp, flag_ov, flag_zr, flag_ne});
        end
        m = '0;
        @(posedge clk); #1;
        rst = 0;
        alu_ov = 0; alu_zr = 0; alu_ne = 0;
    endtask

    task automatic test_forward();
        logic [15:0] exp;
        drive_id(1, 16'hAAAA, 16'hBBBB, 3, 5, ALU_ADD, 0, 0, 1, 6);
        exmem_we = 1; exmem_rd = 3; exmem_data = 16'h1111;
        memwb_we = 1; memwb_rd = 3; memwb_data = 16'h2222;
        tick();
        exp = FWD_ON ? 16'h1111 : 16'hAAAA;
        total++;
        if (pipe.ex_src0 !== exp) begin
            bad++; $display("FAIL fwd_both got %h exp %h", pipe.ex_src0, exp);
        end
        total++;
        if (pipe.ex_src1 !== 16'hBBBB) begin
            bad++; $display("FAIL fwd_nomatch got %h exp bbbb", pipe.ex_src1);
        end
        exmem_we = 0;
        pipe.id_rt = 3;
        tick();
        exp = FWD_ON ? 16'h2222 : 16'hAAAA;
        total++;
        if (pipe.ex_src0 !== exp) begin
            bad++; $display("FAIL fwd_memwb got %h exp %h", pipe.ex_src0, exp);
        end
        exp = FWD_ON ? 16'h2222 : 16'hBBBB;
        total++;
        if (pipe.ex_src1 !== exp) begin
            bad++; $display("FAIL fwd_src1 got %h exp %h", pipe.ex_src1, exp);
        end
        drive_id(1, 16'h0CCC, 16'h0DDD, 0, 5, ALU_ADD, 0, 0, 1, 6);
        exmem_we = 1; exmem_rd = 0; memwb_we = 1; memwb_rd = 0;
        tick();
        total++;
        if (pipe.ex_src0 !== 16'h0CCC) begin
            bad++; $display("FAIL fwd_r0 got %h exp 0ccc", pipe.ex_src0);
        end
        producers_off();
    endtask

    task automatic test_stall_flush();
        drive_id(1, 16'h1234, 16'h5678, 1, 2, ALU_ADD, 4'h3, 1, 1, 4'h7);
        tick();
        total++;
        if ({pipe.ex_valid, pipe.ex_src0, pipe.ex_we} !== {1'b1, 16'h1234, 1'b1}) begin
            bad++; $display("FAIL capture got %h", {pipe.ex_valid, pipe.ex_src0, pipe.ex_we});
        end
        stall = 1;
        drive_id(1, 16'h9999, 16'h8888, 8, 9, ALU_SRA, 4'hF, 0, 0, 4'h2);
        tick();
        tick();
        total++;
        if ({pipe.ex_valid, pipe.ex_src0, pipe.ex_src1, pipe.ex_ctrl, pipe.ex_shamt, pipe.ex_aluOp, pipe.ex_we, pipe.ex_rd}
            !== {1'b1, 16'h1234, 16'h5678, 3'b000, 4'h3, 1'b1, 1'b1, 4'h7}) begin
            bad++; $display("FAIL stall_hold got %h %h %h rd %h", pipe.ex_valid, pipe.ex_src0, pipe.ex_src1, pipe.ex_rd);
        end
        flush = 1;
        tick();
        total++;
        if ({pipe.ex_valid, pipe.ex_we, pipe.ex_aluOp, pipe.ex_src0, pipe.ex_rd} !== 23'd0) begin
            bad++; $display("FAIL flush_over_stall got %h exp 0",
                            {pipe.ex_valid, pipe.ex_we, pipe.ex_aluOp, pipe.ex_src0, pipe.ex_rd});
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_flags();
        drive_id(1, 16'h0010, 16'h0020, 1, 2, ALU_SUB, 0, 1, 1, 3);
        tick();
        alu_ov = 1; alu_ne = 0; alu_zr = 0;
        drive_id(1, 16'h00F0, 16'h000F, 1, 2, ALU_AND, 0, 1, 1, 3);
        tick();
        total++;
        if ({flag_ov, flag_zr, flag_ne} !== 3'b100) begin
            bad++; $display("FAIL flags_sub got %b exp 100", {flag_ov, flag_zr, flag_ne});
        end
        alu_ov = 0; alu_ne = 1; alu_zr = 1;
        pipe.id_valid = 0;
        tick();
        total++;
        if ({flag_ov, flag_zr, flag_ne} !== 3'b110) begin
            bad++; $display("FAIL flags_and got %b exp 110", {flag_ov, flag_zr, flag_ne});
        end
    endtask

    task automatic test_flag_freeze();
        alu_ov = 0; alu_ne = 1; alu_zr = 0;
        drive_id(1, 16'h0001, 16'h0002, 1, 2, ALU_ADD, 0, 0, 1, 3);
        tick();
        stall = 1;
        pipe.id_valid = 0;
        tick();
        tick();
        total++;
        if ({flag_ov, flag_zr, flag_ne} !== 3'b110) begin
            bad++; $display("FAIL flags_stall got %b exp 110", {flag_ov, flag_zr, flag_ne});
        end
        stall = 0;
        tick();
        total++;
        if ({flag_ov, flag_zr, flag_ne} !== 3'b011) begin
            bad++; $display("FAIL flags_release got %b exp 011", {flag_ov, flag_zr, flag_ne});
        end
        alu_ov = 1; alu_ne = 0; alu_zr = 0;
        tick();
        total++;
        if ({flag_ov, flag_zr, flag_ne} !== 3'b011) begin
            bad++; $display("FAIL flags_bubble got %b exp 011", {flag_ov, flag_zr, flag_ne});
        end
        drive_id(1, 16'h0001, 16'h0002, 1, 2, ALU_ADD, 0, 0, 1, 3);
        tick();
        flush = 1;
        tick();
        total++;
        if ({pipe.ex_valid, flag_ov, flag_zr, flag_ne} !== 4'b0110) begin
            bad++; $display("FAIL flags_flush got %b exp 0110", {pipe.ex_valid, flag_ov, flag_zr, flag_ne});
        end
        flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            exmem_we = 1'($urandom); exmem_rd = 4'($urandom_range(0, 3)); exmem_data = 16'($urandom);
            memwb_we = 1'($urandom); memwb_rd = 4'($urandom_range(0, 3)); memwb_data = 16'($urandom);
            alu_ov = 1'($urandom); alu_zr = 1'($urandom); alu_ne = 1'($urandom);
            drive_id(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), 3'($urandom), 4'($urandom), 1'($urandom),
                     1'($urandom), 4'($urandom));
            tick();
            total++;
            if ({pipe.ex_valid, pipe.ex_src0, pipe.ex_src1, pipe.ex_ctrl, pipe.ex_shamt,
                 pipe.ex_aluOp, pipe.ex_we, pipe.ex_rd, flag_ov, flag_zr, flag_ne} !== m) begin
                bad++;
                $display("FAIL rand cycle %0d got %h exp %h", i,
                         {pipe.ex_valid, pipe.ex_src0, pipe.ex_src1, pipe.ex_ctrl, pipe.ex_shamt,
                          pipe.ex_aluOp, pipe.ex_we, pipe.ex_rd, flag_ov, flag_zr, flag_ne}, m);
            end
        end
        stall = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_stall_flush();
        test_flags();
        test_flag_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
